// File: rtl/timer_pkg.sv
// Shared definitions for the DIV/TIMA/TMA/TAC timer block and its bus glue.
package timer_pkg;

   localparam logic [15:0] ADDR_DIV  = 16'hFF04;
   localparam logic [15:0] ADDR_TIMA = 16'hFF05;
   localparam logic [15:0] ADDR_TMA  = 16'hFF06;
   localparam logic [15:0] ADDR_TAC  = 16'hFF07;

   // Bit positions inside the interrupt request/flag vector
   localparam int INT_VBLANK = 0;
   localparam int INT_STAT   = 1;
   localparam int INT_TIMER  = 2;
   localparam int INT_SERIAL = 3;
   localparam int INT_JOYPAD = 4;

   // TAC layout: [2] enable, [1:0] input clock select
   localparam int TAC_W     = 3;
   localparam int TAC_CLK_W = 2;
   localparam int DIV_W     = 16;

   // Divider bit feeding the TIMA edge detector for a given clock select
   function automatic logic tac_tap(input logic [DIV_W-1:0] div,
                                    input logic [TAC_CLK_W-1:0] clk_sel);
      logic bit_v;
      case (clk_sel)
         2'b00:   bit_v = div[9];
         2'b01:   bit_v = div[3];
         2'b10:   bit_v = div[5];
         default: bit_v = div[7];
      endcase
      return bit_v;
   endfunction

endpackage

// File: rtl/timer.sv
// LR35902 timer: free-running DIV, TIMA counting on falling edges of the
// selected divider tap, delayed TMA reload with a one-clock interrupt pulse.
module timer
   import timer_pkg::*;
#(
   parameter int RELOAD_DLY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   input  logic        rd,
   input  logic        wr,
   output logic        sel,
   output logic        int_req
);

   localparam logic [2:0] RELOAD_INIT = 3'(RELOAD_DLY);

   logic [DIV_W-1:0] div_q,  div_d;
   logic [7:0]       tima_q, tima_d;
   logic [7:0]       tma_q,  tma_d;
   logic [TAC_W-1:0] tac_q,  tac_d;
   logic             en_q;
   logic [2:0]       rld_q,  rld_d;
   logic             irq_q,  irq_d;

   logic en;
   logic tick;
   logic wr_div, wr_tima, wr_tma, wr_tac;
   logic rd_unused;

   // Reads have no side effects, so the strobe is not needed
   assign rd_unused = rd;

   assign sel     = (a[15:2] == ADDR_DIV[15:2]);
   assign wr_div  = wr && (a == ADDR_DIV);
   assign wr_tima = wr && (a == ADDR_TIMA);
   assign wr_tma  = wr && (a == ADDR_TMA);
   assign wr_tac  = wr && (a == ADDR_TAC);

   // Gated tap; a 1->0 transition of it is a tick, including the ones caused
   // by clearing DIV or rewriting TAC (the DMG glitch)
   assign en      = tac_q[2] & tac_tap(div_q, tac_q[TAC_CLK_W-1:0]);
   assign tick    = en_q & ~en;
   assign int_req = irq_q;

   // Bus read mux; unmapped addresses float high
   always_comb begin
      dout = 8'hFF;
      if (sel) begin
         case (a[1:0])
            2'b00:   dout = div_q[15:8];
            2'b01:   dout = tima_q;
            2'b10:   dout = tma_q;
            default: dout = {5'b11111, tac_q};
         endcase
      end
   end

   // Next-state: reload clock beats a TIMA write, a TIMA write beats a tick
   always_comb begin
      div_d  = wr_div ? '0 : div_q + 16'd1;
      tma_d  = wr_tma ? din : tma_q;
      tac_d  = wr_tac ? din[TAC_W-1:0] : tac_q;
      tima_d = tima_q;
      rld_d  = rld_q;
      irq_d  = 1'b0;
      if (rld_q == 3'd1) begin
         tima_d = tma_d;
         rld_d  = 3'd0;
         irq_d  = 1'b1;
      end else if (wr_tima) begin
         tima_d = din;
         rld_d  = 3'd0;
      end else begin
         if (rld_q != 3'd0) begin
            rld_d = rld_q - 3'd1;
         end
         if (tick) begin
            if (tima_q == 8'hFF) begin
               tima_d = 8'h00;
               rld_d  = RELOAD_INIT;
            end else begin
               tima_d = tima_q + 8'd1;
            end
         end
      end
   end

   // State registers; reset drops any pending reload and interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         tima_q <= 8'h00;
         tma_q  <= 8'h00;
         tac_q  <= '0;
         en_q   <= 1'b0;
         rld_q  <= 3'd0;
         irq_q  <= 1'b0;
      end else begin
         div_q  <= div_d;
         tima_q <= tima_d;
         tma_q  <= tma_d;
         tac_q  <= tac_d;
         en_q   <= en;
         rld_q  <= rld_d;
         irq_q  <= irq_d;
      end
   end

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for the timer block with an event-based reference model.
module tb_timer;

   localparam int DLY = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] a = 16'h0000;
   logic [7:0]  din = 8'h00;
   logic [7:0]  dout;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic        sel;
   logic        int_req;

   int checks = 0;
   int failures = 0;

   timer #(.RELOAD_DLY(DLY)) dut (
      .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout),
      .rd(rd), .wr(wr), .sel(sel), .int_req(int_req)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // DIV is derived from the edge count since the last clear; the reload is
   // scheduled as an absolute edge number.
   int TAPS [4] = '{9, 3, 5, 7};
   int cyc = 0;
   int div_base = 0;
   int m_tima = 0, m_tma = 0, m_tac = 0;
   int reload_at = -1;
   bit m_irq = 0;
   bit en_last = 0;

   function automatic int cur_div();
      return (cyc - div_base) & 16'hFFFF;
   endfunction

   function automatic bit cur_en();
      return (m_tac[2] == 1'b1) && (((cur_div() >> TAPS[m_tac & 3]) & 1) == 1);
   endfunction

   function automatic logic [7:0] m_read(input logic [15:0] ad);
      case (ad)
         16'hFF04: return 8'((cur_div() >> 8) & 255);
         16'hFF05: return 8'(m_tima);
         16'hFF06: return 8'(m_tma);
         16'hFF07: return {5'b11111, 3'(m_tac)};
         default:  return 8'hFF;
      endcase
   endfunction

   task automatic model_reset();
      cyc++;
      div_base = cyc;
      m_tima = 0; m_tma = 0; m_tac = 0;
      reload_at = -1; m_irq = 0; en_last = 0;
   endtask

   task automatic model_step(input logic w, input logic [15:0] ad, input logic [7:0] d);
      bit en_now, tk, wd, wt, wm, wc;
      en_now = cur_en();
      tk = en_last && !en_now;
      wd = w && ad == 16'hFF04;
      wt = w && ad == 16'hFF05;
      wm = w && ad == 16'hFF06;
      wc = w && ad == 16'hFF07;
      m_irq = 0;
      if (reload_at == cyc + 1) begin
         m_tima = wm ? int'(d) : m_tma;
         m_irq = 1;
         reload_at = -1;
      end else if (wt) begin
         m_tima = d;
         reload_at = -1;
      end else if (tk) begin
         if (m_tima == 255) begin
            m_tima = 0;
            reload_at = cyc + 1 + DLY;
         end else begin
            m_tima = m_tima + 1;
         end
      end
      if (wm) m_tma = d;
      if (wc) m_tac = d & 7;
      en_last = en_now;
      cyc++;
      if (wd) div_base = cyc;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cycle(input logic r, input logic w, input logic [15:0] ad, input logic [7:0] d);
      rst = r; wr = w; a = ad; din = d;
      @(posedge clk);
      if (r) model_reset(); else model_step(w, ad, d);
      #1;
      rst = 1'b0; wr = 1'b0; a = 16'h0000; din = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic peek(input logic [15:0] ad, output logic [7:0] d);
      a = ad; rd = 1'b1;
      #1;
      d = dout;
      rd = 1'b0;
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, 16'h0000, 8'h00);
      cycle(1'b1, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic wait_ovf(output bit ok);
      ok = 0;
      for (int i = 0; i < 600 && !ok; i++) begin
         cycle(1'b0, 1'b0, 16'h0000, 8'h00);
         if (reload_at != -1) ok = 1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] v;
      do_reset();
      checks++;
      if (int_req !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", int_req); end
      for (int k = 4; k <= 7; k++) begin
         peek(16'(16'hFF00 + k), v);
         checks++;
         if (v !== ((k == 7) ? 8'hF8 : 8'h00)) begin
            failures++; $display("FAIL reset_reg%0d got=%h want=%h", k, v, (k == 7) ? 8'hF8 : 8'h00);
         end
      end
      peek(16'hFF03, v);
      checks++;
      if (sel !== 1'b0 || v !== 8'hFF) begin
         failures++; $display("FAIL unmapped_read sel=%b dout=%h want sel=0 dout=ff", sel, v);
      end
   endtask

   task automatic test_div();
      logic [7:0] v;
      do_reset();
      idle(256);
      peek(16'hFF04, v);
      checks++;
      if (v !== 8'h01 || v !== m_read(16'hFF04)) begin
         failures++; $display("FAIL div_256 got=%h want=01", v);
      end
      cycle(1'b0, 1'b1, 16'hFF04, 8'hAB);
      peek(16'hFF04, v);
      checks++;
      if (v !== 8'h00) begin failures++; $display("FAIL div_clear got=%h want=00", v); end
   endtask

   task automatic test_overflow();
      logic [7:0] obs_t [120];
      logic       obs_i [120];
      int first, zeros, pulses;
      do_reset();
      cycle(1'b0, 1'b1, 16'hFF07, 8'h05);
      cycle(1'b0, 1'b1, 16'hFF05, 8'hFE);
      cycle(1'b0, 1'b1, 16'hFF06, 8'h40);
      for (int i = 0; i < 120; i++) begin
         cycle(1'b0, 1'b0, 16'h0000, 8'h00);
         peek(16'hFF05, obs_t[i]);
         obs_i[i] = int_req;
         checks++;
         if (obs_t[i] !== 8'(m_tima) || obs_i[i] !== m_irq) begin
            failures++; $display("FAIL ovf_cyc%0d tima=%h irq=%b want tima=%h irq=%b",
                                 i, obs_t[i], obs_i[i], 8'(m_tima), m_irq);
         end
      end
      first = -1; zeros = 0; pulses = 0;
      for (int i = 1; i < 120; i++) begin
         if (first < 0 && obs_t[i] == 8'h00 && obs_t[i-1] == 8'hFF) first = i;
         if (obs_i[i] === 1'b1) pulses++;
      end
      if (first >= 0) begin
         for (int i = first; i < 120 && obs_t[i] == 8'h00; i++) zeros++;
      end
      checks++;
      if (first < 0 || zeros != 4 || first + 4 >= 120 || obs_t[first+4] !== 8'h40 ||
          obs_i[first+4] !== 1'b1 || pulses != 1) begin
         failures++; $display("FAIL ovf_shape zeros=%0d pulses=%0d want zeros=4 pulses=1 reload=40",
                              zeros, pulses);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] v0, v;
      bit found;
      do_reset();
      cycle(1'b0, 1'b1, 16'hFF07, 8'h04);
      found = 0;
      for (int i = 0; i < 2048 && !found; i++) begin
         if (((cur_div() >> 9) & 1) == 1) found = 1;
         else cycle(1'b0, 1'b0, 16'h0000, 8'h00);
      end
      checks++;
      if (!found) begin failures++; $display("FAIL glitch_wait timeout want div9=1"); end
      peek(16'hFF05, v0);
      cycle(1'b0, 1'b1, 16'hFF04, 8'h00);
      idle(2);
      peek(16'hFF05, v);
      checks++;
      if (v !== v0 + 8'd1 || v !== 8'(m_tima)) begin
         failures++; $display("FAIL glitch_tick got=%h want=%h", v, v0 + 8'd1);
      end
      v0 = v;
      cycle(1'b0, 1'b1, 16'hFF04, 8'h00);
      idle(2);
      peek(16'hFF05, v);
      checks++;
      if (v !== v0) begin failures++; $display("FAIL glitch_none got=%h want=%h", v, v0); end
   endtask

   task automatic test_cancel();
      logic [7:0] v;
      bit ok;
      int pulses;
      do_reset();
      cycle(1'b0, 1'b1, 16'hFF07, 8'h05);
      cycle(1'b0, 1'b1, 16'hFF06, 8'h40);
      cycle(1'b0, 1'b1, 16'hFF05, 8'hFF);
      wait_ovf(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL cancel_wait timeout want overflow"); end
      idle(1);
      cycle(1'b0, 1'b1, 16'hFF05, 8'h77);
      peek(16'hFF05, v);
      checks++;
      if (v !== 8'h77) begin failures++; $display("FAIL cancel_write got=%h want=77", v); end
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 16'h0000, 8'h00);
         if (int_req === 1'b1) pulses++;
      end
      peek(16'hFF05, v);
      checks++;
      if (pulses != 0 || v !== 8'(m_tima) || v == 8'h40) begin
         failures++; $display("FAIL cancel_noreload pulses=%0d tima=%h want pulses=0 tima=%h",
                              pulses, v, 8'(m_tima));
      end
   endtask

   task automatic test_tma_window();
      logic [7:0] v;
      bit ok, seen;
      do_reset();
      cycle(1'b0, 1'b1, 16'hFF07, 8'h05);
      cycle(1'b0, 1'b1, 16'hFF06, 8'h40);
      cycle(1'b0, 1'b1, 16'hFF05, 8'hFF);
      wait_ovf(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL tma_wait timeout want overflow"); end
      idle(1);
      cycle(1'b0, 1'b1, 16'hFF06, 8'h99);
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         cycle(1'b0, 1'b0, 16'h0000, 8'h00);
         if (int_req === 1'b1) seen = 1;
      end
      peek(16'hFF05, v);
      checks++;
      if (!seen || v !== 8'h99) begin
         failures++; $display("FAIL tma_reload irq_seen=%0d tima=%h want 1 99", seen, v);
      end
   endtask

   task automatic test_reset_window();
      logic [7:0] v;
      bit ok;
      int pulses;
      do_reset();
      cycle(1'b0, 1'b1, 16'hFF07, 8'h05);
      cycle(1'b0, 1'b1, 16'hFF06, 8'h40);
      cycle(1'b0, 1'b1, 16'hFF05, 8'hFF);
      wait_ovf(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rstwin_wait timeout want overflow"); end
      idle(1);
      cycle(1'b1, 1'b0, 16'h0000, 8'h00);
      for (int k = 4; k <= 7; k++) begin
         peek(16'(16'hFF00 + k), v);
         checks++;
         if (v !== ((k == 7) ? 8'hF8 : 8'h00)) begin
            failures++; $display("FAIL rstwin_reg%0d got=%h want=%h", k, v, (k == 7) ? 8'hF8 : 8'h00);
         end
      end
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, 16'h0000, 8'h00);
         if (int_req === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL rstwin_irq pulses=%0d want=0", pulses); end
   endtask

   task automatic test_random();
      logic [7:0] v;
      logic [15:0] ad;
      int r;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 999);
         if (r < 3) begin
            cycle(1'b1, 1'b0, 16'h0000, 8'h00);
         end else if (r < 250) begin
            ad = 16'(16'hFF05 + $urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) ad = 16'hFF04;
            if ($urandom_range(0, 19) == 0) ad = 16'hFF08;
            v = 8'($urandom_range(0, 255));
            if (ad == 16'hFF05 && $urandom_range(0, 1) == 1) v = 8'hFF;
            cycle(1'b0, 1'b1, ad, v);
         end else begin
            cycle(1'b0, 1'b0, 16'h0000, 8'h00);
         end
         checks++;
         if (int_req !== m_irq) begin
            failures++; $display("FAIL rand_irq cyc%0d got=%b want=%b", i, int_req, m_irq);
         end
         ad = 16'(16'hFF02 + $urandom_range(0, 7));
         peek(ad, v);
         checks++;
         if (v !== m_read(ad) || sel !== (ad >= 16'hFF04 && ad <= 16'hFF07)) begin
            failures++; $display("FAIL rand_read cyc%0d addr=%h got=%h sel=%b want=%h",
                                 i, ad, v, sel, m_read(ad));
         end
      end
   endtask

   initial begin
      test_reset();
      test_div();
      test_overflow();
      test_glitch();
      test_cancel();
      test_tma_window();
      test_reset_window();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
